// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, instruction field
// positions and the default reset PC.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int unsigned XLEN = 32;

  localparam int unsigned OPC_HI   = 31;
  localparam int unsigned OPC_LO   = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential word address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/ir_fields.sv
// Combinational slicer of an instruction word into its MIPS fields; shared by
// fetch, decode and the sign extender.
module ir_fields
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  // Shift amount bits are not exported by this slicer.
  logic unused_shamt;
  assign unused_shamt = ^ir[10:6];

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign funct  = ir[FUNCT_HI:FUNCT_LO];
  assign imm16  = ir[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch: PC, req/ack memory read, instruction register
// with valid/ready handoff to decode, and redirect with outstanding-read drain.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  redirect_aligned;

  assign redirect_aligned = redirect_pc & ~32'h0000_0003;
  assign mem_addr         = pc;

  // FSM plus PC/IR registers; mem_req and ir_valid are registered alongside
  // the state so neither depends combinationally on mem_ack or ir_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= 32'h0;
      ir_pc    <= 32'h0;
      ir_pc4   <= 32'h4;
      ir_valid <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      if (redirect) begin
        pc <= redirect_aligned;
      end
      case (state)
        IDLE: begin
          state   <= FETCH;
          mem_req <= 1'b1;
        end
        FETCH: begin
          if (redirect) begin
            // With a same-cycle ack the read is done; otherwise it must drain.
            state   <= mem_ack ? FETCH : DRAIN;
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            ir       <= mem_rdata;
            ir_pc    <= pc;
            ir_pc4   <= pc_plus4(pc);
            pc       <= pc_plus4(pc);
            state    <= HOLD;
            mem_req  <= 1'b0;
            ir_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect || ir_ready) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            ir_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          mem_req  <= 1'b0;
          ir_valid <= 1'b0;
        end
      endcase
    end
  end

  ir_fields u_ir_fields (
    .ir     (ir),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .funct  (funct),
    .imm16  (imm16)
  );

endmodule
